// File: rtl/attempt_capture_n_if.sv
// rtl/attempt_capture_n_if.sv - player/comparator signal bundle for attempt_capture_n
// master drives the player and comparator inputs; slave is the capture FSM.
interface attempt_capture_n_if #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 3
);
  logic             i_start;
  logic             i_enter;
  logic [WIDTH-1:0] i_switches_attempt;
  logic             i_check_valid;
  logic             i_attempt_state;
  logic [WIDTH-1:0] o_attempt;
  logic [WIDTH-1:0] o_display;
  logic             o_check_req;
  logic [CNT_W-1:0] o_tries;
  logic             o_repeat;
  logic             o_game_won;
  logic             o_game_lost;

  modport master (
    output i_start, i_enter, i_switches_attempt, i_check_valid, i_attempt_state,
    input  o_attempt, o_display, o_check_req, o_tries, o_repeat, o_game_won, o_game_lost
  );

  modport slave (
    input  i_start, i_enter, i_switches_attempt, i_check_valid, i_attempt_state,
    output o_attempt, o_display, o_check_req, o_tries, o_repeat, o_game_won, o_game_lost
  );
endinterface

// File: rtl/attempt_capture_n.sv
// rtl/attempt_capture_n.sv - guess-capture FSM with duplicate rejection and try limit
// Captures a guess on each Enter rising edge, waits for a comparator verdict, tracks win/loss.
module attempt_capture_n #(
  parameter int WIDTH     = 3,
  parameter int MAX_TRIES = 7,
  parameter int CNT_W     = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  attempt_capture_n_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ENTER,
    S_CAPTURE,
    S_CHECK,
    S_WIN,
    S_LOSE
  } state_t;

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_TRIES);

  state_t           r_state, w_state_next;
  logic             r_enter_old;
  logic [WIDTH-1:0] r_attempt, w_attempt_next;
  logic [CNT_W-1:0] r_tries, w_tries_next;
  logic             r_repeat, w_repeat_next;
  logic             r_won, w_won_next;
  logic             r_lost, w_lost_next;
  logic             w_enter_rise;
  logic             w_duplicate;

  // Enter_Old resets high so a button held through reset never looks like a press.
  assign w_enter_rise = bus.i_enter & ~r_enter_old;
  assign w_duplicate  = (r_tries != '0) && (bus.i_switches_attempt == r_attempt);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_enter_old <= 1'b1;
      r_attempt   <= '0;
      r_tries     <= '0;
      r_repeat    <= 1'b0;
      r_won       <= 1'b0;
      r_lost      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_enter_old <= bus.i_enter;
      r_attempt   <= w_attempt_next;
      r_tries     <= w_tries_next;
      r_repeat    <= w_repeat_next;
      r_won       <= w_won_next;
      r_lost      <= w_lost_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_attempt_next = r_attempt;
    w_tries_next   = r_tries;
    w_repeat_next  = 1'b0;
    w_won_next     = r_won;
    w_lost_next    = r_lost;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_state_next = S_WAIT_ENTER;
          w_tries_next = '0;
          w_won_next   = 1'b0;
          w_lost_next  = 1'b0;
        end
      end
      S_WAIT_ENTER: begin
        if (w_enter_rise) begin
          w_state_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (w_duplicate) begin
          w_repeat_next = 1'b1;
          w_state_next  = S_WAIT_ENTER;
        end else begin
          w_attempt_next = bus.i_switches_attempt;
          w_tries_next   = r_tries + 1'b1;
          w_state_next   = S_CHECK;
        end
      end
      S_CHECK: begin
        // A correct final try counts as a win, not a loss.
        if (bus.i_check_valid) begin
          if (bus.i_attempt_state) begin
            w_state_next = S_WIN;
            w_won_next   = 1'b1;
          end else if (r_tries == LP_MAX) begin
            w_state_next = S_LOSE;
            w_lost_next  = 1'b1;
          end else begin
            w_state_next = S_WAIT_ENTER;
          end
        end
      end
      S_WIN, S_LOSE: begin
        if (bus.i_start) begin
          w_state_next = S_WAIT_ENTER;
          w_tries_next = '0;
          w_won_next   = 1'b0;
          w_lost_next  = 1'b0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign bus.o_attempt   = r_attempt;
  assign bus.o_display   = ~r_attempt;
  assign bus.o_check_req = (r_state == S_CHECK);
  assign bus.o_tries     = r_tries;
  assign bus.o_repeat    = r_repeat;
  assign bus.o_game_won  = r_won;
  assign bus.o_game_lost = r_lost;
endmodule

// File: doc/attempt_capture_n.md
ATTEMPT_CAPTURE_N -- requirements
Module: attempt_capture_n

Interface
REQ-001 Parameter WIDTH, default 3, attempt/switch width in bits (1..16).
REQ-002 Parameter MAX_TRIES, default 7, tries allowed per game (1..2^CNT_W-1).
REQ-003 Parameter CNT_W, default 3, width of try counter.
REQ-004 Clk  input  1  sole clock, all state updates on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Start  input  1  level; begins or restarts a game.
REQ-007 Enter  input  1  level from pushbutton; rising edge submits an attempt.
REQ-008 Switches_Attempt  input  WIDTH  player guess.
REQ-009 Check_Valid  input  1  comparator result valid, sampled only in CHECK.
REQ-010 Attempt_State  input  1  1 = guess correct, 0 = incorrect; qualified by Check_Valid.
REQ-011 Attempt  output  WIDTH  last captured guess.
REQ-012 Display  output  WIDTH  active-low LED mirror of Attempt.
REQ-013 Check_Req  output  1  high while awaiting comparator result.
REQ-014 Tries  output  CNT_W  tries consumed in current game.
REQ-015 Repeat  output  1  one-cycle pulse: duplicate guess rejected.
REQ-016 Game_Won  output  1  sticky win flag.
REQ-017 Game_Lost  output  1  sticky loss flag.

Function
REQ-018 States SHALL be IDLE, WAIT_ENTER, CAPTURE, CHECK, WIN, LOSE; all outputs registered or decoded from registered state.
REQ-019 Enter edge: Enter_Old registered every cycle; Enter_Rise = Enter & ~Enter_Old; Enter_Old SHALL reset to 1 (button held through reset gives no edge).
REQ-020 IDLE: Start=1 -> WAIT_ENTER next cycle; Tries, Game_Won, Game_Lost cleared.
REQ-021 WAIT_ENTER: Enter_Rise -> CAPTURE next cycle; otherwise hold.
REQ-022 CAPTURE, duplicate case (Tries!=0 and Switches_Attempt==Attempt): Attempt, Tries unchanged, Repeat=1 for exactly one cycle, -> WAIT_ENTER.
REQ-023 CAPTURE, normal case: Attempt<=Switches_Attempt, Display<=~Switches_Attempt, Tries<=Tries+1, -> CHECK; Display updates same edge as Attempt (latency 2 cycles from Enter_Rise sample).
REQ-024 CHECK: Check_Req=1 for every cycle in CHECK, 0 elsewhere; hold until Check_Valid=1, no timeout.
REQ-025 CHECK with Check_Valid=1: Attempt_State=1 -> WIN, Game_Won<=1; else Tries==MAX_TRIES -> LOSE, Game_Lost<=1; else -> WAIT_ENTER.
REQ-026 Win takes priority over loss when correct guess is the MAX_TRIES-th try.
REQ-027 WIN/LOSE: Enter ignored; Start=1 -> WAIT_ENTER, Tries/Game_Won/Game_Lost cleared, Attempt and Display retained.
REQ-028 Start SHALL be ignored in WAIT_ENTER, CAPTURE, CHECK (no mid-game restart).
REQ-029 Check_Valid/Attempt_State outside CHECK SHALL be ignored.
REQ-030 Tries SHALL never exceed MAX_TRIES; no wrap.
REQ-031 Game_Won and Game_Lost SHALL never both be 1.
REQ-032 Switches_Attempt sampled only in CAPTURE; changes elsewhere have no effect.

Reset
REQ-033 Reset=1 at a rising edge SHALL, in any state, force IDLE, Attempt=0, Display=all ones, Tries=0, Check_Req=0, Repeat=0, Game_Won=0, Game_Lost=0, Enter_Old=1.
REQ-034 Reset SHALL override Start, Enter and Check_Valid in the same cycle.
REQ-035 Reset mid-CHECK SHALL drop Check_Req next cycle; a late Check_Valid SHALL be ignored.

Verification
REQ-036 WIDTH=3: Start, switches=3'b101, Enter pulse, Check_Valid=1/Attempt_State=1 three cycles later -> Attempt=101, Display=010, Tries=1, Game_Won=1, Check_Req high for exactly 3 cycles.
REQ-037 MAX_TRIES=2: two distinct wrong guesses -> Tries=2, Game_Lost=1, Game_Won=0; further Enter edges leave Tries=2.
REQ-038 Guess 3'b011 wrong, then 3'b011 again -> Repeat one-cycle pulse, Tries stays 1, Check_Req stays low.
REQ-039 MAX_TRIES=2: wrong then correct on second try -> Game_Won=1, Game_Lost=0.
REQ-040 Enter held high across Reset release -> no capture until Enter drops and rises again; Reset asserted while in CHECK -> IDLE, all outputs at reset values next cycle.
REQ-041 After WIN, Start=1 -> WAIT_ENTER, Tries=0, Game_Won=0, Attempt/Display unchanged.
